// File: rtl/rob_pkg.sv
// rob_pkg: shared entry layout, FSM state and helpers for the reorder buffer
package rob_pkg;
  localparam int ROB_ARCH_W = 5;
  localparam int ROB_PHYS_W = 8;
  localparam int ROB_OP_W = 11;
  typedef struct packed {
    logic valid;
    logic done;
    logic exc;
    logic [ROB_ARCH_W-1:0] arch;
    logic [ROB_PHYS_W-1:0] phys;
    logic [ROB_OP_W-1:0] op;
  } rob_entry_t;
  typedef enum logic {RUN, FLUSH} rob_state_t;
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n += {31'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/rob_nway_commit_sel.sv
// rob_commit_sel: prefix scan from head finding retirable entries and a blocking exception
module rob_commit_sel #(
  parameter int WIDTH = 4,
  localparam int KW = $clog2(WIDTH + 1),
  localparam int LW = WIDTH > 1 ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] valid_i,
  input  logic [WIDTH-1:0] done_i,
  input  logic [WIDTH-1:0] exc_i,
  output logic [KW-1:0]    k_o,
  output logic             exc_hit_o,
  output logic [LW-1:0]    exc_lane_o
);
  logic stop;
  always_comb begin
    k_o = '0;
    exc_hit_o = 1'b0;
    exc_lane_o = '0;
    stop = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!stop) begin
        if (valid_i[i] && done_i[i] && !exc_i[i]) k_o = k_o + KW'(1);
        else begin
          stop = 1'b1;
          exc_hit_o = valid_i[i] & done_i[i] & exc_i[i];
          exc_lane_o = LW'(i);
        end
      end
    end
  end
endmodule

// File: rtl/rob_nway.sv
// rob_nway: N-way reorder buffer with in-order retire and flush on excepting head
module rob_nway import rob_pkg::*; #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 4,
  parameter int WB_PORTS = 4,
  parameter int ARCH_W = ROB_ARCH_W,
  parameter int PHYS_W = ROB_PHYS_W,
  parameter int OP_W = ROB_OP_W,
  localparam int IDX_W = $clog2(DEPTH),
  localparam int CNT_W = IDX_W + 1,
  localparam int NC_W = $clog2(WIDTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [WIDTH-1:0]          disp_valid_i,
  input  logic [WIDTH*ARCH_W-1:0]   disp_arch_i,
  input  logic [WIDTH*PHYS_W-1:0]   disp_phys_i,
  input  logic [WIDTH*OP_W-1:0]     disp_op_i,
  output logic                      disp_ready_o,
  output logic [WIDTH*IDX_W-1:0]    disp_idx_o,
  input  logic [WB_PORTS-1:0]       wb_valid_i,
  input  logic [WB_PORTS*IDX_W-1:0] wb_idx_i,
  input  logic [WB_PORTS-1:0]       wb_exc_i,
  output logic [WIDTH-1:0]          cm_valid_o,
  output logic [WIDTH*ARCH_W-1:0]   cm_arch_o,
  output logic [WIDTH*PHYS_W-1:0]   cm_phys_o,
  output logic [NC_W-1:0]           num_commit_o,
  output logic                      exc_valid_o,
  output logic [IDX_W-1:0]          exc_idx_o,
  output logic [OP_W-1:0]           exc_op_o,
  output logic [CNT_W-1:0]          count_o,
  output logic                      full_o,
  output logic                      empty_o
);
  localparam int LW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  rob_entry_t ent_q [DEPTH];
  rob_entry_t ent_d [DEPTH];
  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d, exc_idx_q, exc_idx_d;
  logic [CNT_W-1:0] count_q, count_d, n_disp;
  rob_state_t state_q, state_d;
  logic [WIDTH-1:0] cm_valid_q, cm_valid_d, sel_v, sel_d, sel_e;
  logic [WIDTH*ARCH_W-1:0] cm_arch_q, cm_arch_d;
  logic [WIDTH*PHYS_W-1:0] cm_phys_q, cm_phys_d;
  logic [NC_W-1:0] num_commit_q, num_commit_d, k;
  logic exc_valid_q, exc_valid_d, exc_hit, disp_fire;
  logic [OP_W-1:0] exc_op_q, exc_op_d;
  logic [LW-1:0] exc_lane;
  // ready uses the pre-commit count, so it never relies on same-cycle retirement
  assign disp_ready_o = (state_q == RUN) && ((CNT_W'(DEPTH) - count_q) >= CNT_W'(WIDTH));
  assign disp_fire = disp_valid_i[0] & disp_ready_o;
  assign n_disp = disp_fire ? CNT_W'(popcount(32'(disp_valid_i))) : '0;
  always_comb begin
    disp_idx_o = '0;
    sel_v = '0;
    sel_d = '0;
    sel_e = '0;
    for (int i = 0; i < WIDTH; i++) begin
      disp_idx_o[i*IDX_W +: IDX_W] = tail_q + IDX_W'(i);
      sel_v[i] = ent_q[head_q + IDX_W'(i)].valid;
      sel_d[i] = ent_q[head_q + IDX_W'(i)].done;
      sel_e[i] = ent_q[head_q + IDX_W'(i)].exc;
    end
  end
  rob_commit_sel #(.WIDTH(WIDTH)) u_sel (
    .valid_i(sel_v), .done_i(sel_d), .exc_i(sel_e),
    .k_o(k), .exc_hit_o(exc_hit), .exc_lane_o(exc_lane)
  );
  always_comb begin
    ent_d = ent_q;
    head_d = head_q;
    tail_d = tail_q;
    count_d = count_q;
    state_d = RUN;
    cm_valid_d = '0;
    cm_arch_d = cm_arch_q;
    cm_phys_d = cm_phys_q;
    num_commit_d = '0;
    exc_valid_d = 1'b0;
    exc_idx_d = exc_idx_q;
    exc_op_d = exc_op_q;
    if (state_q == FLUSH) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i].valid = 1'b0;
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end else begin
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_valid_i[p] && ent_q[wb_idx_i[p*IDX_W +: IDX_W]].valid) begin
          ent_d[wb_idx_i[p*IDX_W +: IDX_W]].done = 1'b1;
          ent_d[wb_idx_i[p*IDX_W +: IDX_W]].exc = ent_d[wb_idx_i[p*IDX_W +: IDX_W]].exc | wb_exc_i[p];
        end
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (NC_W'(i) < k) begin
          ent_d[head_q + IDX_W'(i)].valid = 1'b0;
          cm_valid_d[i] = 1'b1;
          cm_arch_d[i*ARCH_W +: ARCH_W] = ent_q[head_q + IDX_W'(i)].arch;
          cm_phys_d[i*PHYS_W +: PHYS_W] = ent_q[head_q + IDX_W'(i)].phys;
        end
      end
      num_commit_d = k;
      head_d = head_q + IDX_W'(k);
      if (exc_hit) begin
        exc_valid_d = 1'b1;
        exc_idx_d = head_q + IDX_W'(exc_lane);
        exc_op_d = ent_q[head_q + IDX_W'(exc_lane)].op;
        state_d = FLUSH;
      end
      for (int i = 0; i < WIDTH; i++) begin
        if (disp_fire && disp_valid_i[i])
          ent_d[tail_q + IDX_W'(i)] = '{valid: 1'b1, done: 1'b0, exc: 1'b0,
                                        arch: disp_arch_i[i*ARCH_W +: ARCH_W],
                                        phys: disp_phys_i[i*PHYS_W +: PHYS_W],
                                        op: disp_op_i[i*OP_W +: OP_W]};
      end
      tail_d = tail_q + IDX_W'(n_disp);
      count_d = count_q + n_disp - CNT_W'(k);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      state_q <= RUN;
      cm_valid_q <= '0;
      cm_arch_q <= '0;
      cm_phys_q <= '0;
      num_commit_q <= '0;
      exc_valid_q <= 1'b0;
      exc_idx_q <= '0;
      exc_op_q <= '0;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      state_q <= state_d;
      cm_valid_q <= cm_valid_d;
      cm_arch_q <= cm_arch_d;
      cm_phys_q <= cm_phys_d;
      num_commit_q <= num_commit_d;
      exc_valid_q <= exc_valid_d;
      exc_idx_q <= exc_idx_d;
      exc_op_q <= exc_op_d;
    end
  end
  assign cm_valid_o = cm_valid_q;
  assign cm_arch_o = cm_arch_q;
  assign cm_phys_o = cm_phys_q;
  assign num_commit_o = num_commit_q;
  assign exc_valid_o = exc_valid_q;
  assign exc_idx_o = exc_idx_q;
  assign exc_op_o = exc_op_q;
  assign count_o = count_q;
  assign full_o = count_q == CNT_W'(DEPTH);
  assign empty_o = count_q == '0;
endmodule

// File: tb/tb_rob_nway.sv
// tb_rob_nway: directed and random checks of rob_nway against a queue-based model
module tb_rob_nway;
  localparam int D = 128, W = 4, P = 4, AW = 5, PW = 8, OW = 11, IW = 7, CW = 8, NW = 3;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [W-1:0] disp_valid = '0;
  logic [W*AW-1:0] disp_arch = '0;
  logic [W*PW-1:0] disp_phys = '0;
  logic [W*OW-1:0] disp_op = '0;
  logic [P-1:0] wb_valid = '0, wb_exc = '0;
  logic [P*IW-1:0] wb_idx = '0;
  logic disp_ready, exc_valid, full, empty;
  logic [W*IW-1:0] disp_idx;
  logic [W-1:0] cm_valid;
  logic [W*AW-1:0] cm_arch;
  logic [W*PW-1:0] cm_phys;
  logic [NW-1:0] num_commit;
  logic [IW-1:0] exc_idx;
  logic [OW-1:0] exc_op;
  logic [CW-1:0] count;
  rob_nway dut (
    .clk(clk), .reset(reset), .disp_valid_i(disp_valid), .disp_arch_i(disp_arch),
    .disp_phys_i(disp_phys), .disp_op_i(disp_op), .disp_ready_o(disp_ready), .disp_idx_o(disp_idx),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_exc_i(wb_exc), .cm_valid_o(cm_valid),
    .cm_arch_o(cm_arch), .cm_phys_o(cm_phys), .num_commit_o(num_commit), .exc_valid_o(exc_valid),
    .exc_idx_o(exc_idx), .exc_op_o(exc_op), .count_o(count), .full_o(full), .empty_o(empty)
  );
  // model: program-order queue of live instructions; head is implied by tail and size
  typedef struct {int idx; int arch; int phys; int op; bit done; bit exc;} m_t;
  m_t mq[$];
  int m_tail;
  bit m_flush, e_excv, chk_en = 0;
  bit [W-1:0] e_cmv;
  int e_arch[W], e_phys[W];
  int e_nc, e_exci, e_exco;
  int total = 0, bad = 0;
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int m_head();
    return (m_tail - mq.size() + D) % D;
  endfunction
  function automatic bit m_ready();
    return !m_flush && (D - mq.size()) >= W;
  endfunction
  task automatic model_reset();
    mq.delete();
    m_tail = 0;
    m_flush = 0;
    e_cmv = '0;
    e_nc = 0;
    e_excv = 0;
    e_exci = 0;
    e_exco = 0;
  endtask
  task automatic model_step();
    int k, pos, hd;
    bit hit, rdy;
    m_t t;
    if (m_flush) begin
      mq.delete();
      m_tail = 0;
      m_flush = 0;
      e_cmv = '0;
      e_nc = 0;
      e_excv = 0;
      return;
    end
    k = 0;
    while (k < W && k < mq.size() && mq[k].done && !mq[k].exc) k++;
    hit = k < W && k < mq.size() && mq[k].done && mq[k].exc;
    e_cmv = '0;
    for (int i = 0; i < k; i++) begin
      e_cmv[i] = 1'b1;
      e_arch[i] = mq[i].arch;
      e_phys[i] = mq[i].phys;
    end
    e_nc = k;
    e_excv = hit;
    if (hit) begin
      e_exci = mq[k].idx;
      e_exco = mq[k].op;
    end
    rdy = m_ready();
    hd = m_head();
    for (int p = 0; p < P; p++) begin
      if (wb_valid[p]) begin
        pos = (int'(wb_idx[p*IW +: IW]) - hd + D) % D;
        if (pos < mq.size()) begin
          t = mq[pos];
          t.done = 1;
          t.exc = t.exc | wb_exc[p];
          mq[pos] = t;
        end
      end
    end
    repeat (k) void'(mq.pop_front());
    if (disp_valid[0] && rdy)
      for (int i = 0; i < W; i++)
        if (disp_valid[i]) begin
          mq.push_back('{m_tail, int'(disp_arch[i*AW +: AW]), int'(disp_phys[i*PW +: PW]),
                         int'(disp_op[i*OW +: OW]), 0, 0});
          m_tail = (m_tail + 1) % D;
        end
    if (hit) m_flush = 1;
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      check("disp_ready", disp_ready, m_ready());
      check("count", count, mq.size());
      check("full", full, mq.size() == D);
      check("empty", empty, mq.size() == 0);
      check("cm_valid", cm_valid, e_cmv);
      check("num_commit", num_commit, e_nc);
      check("exc_valid", exc_valid, e_excv);
      if (e_excv) begin
        check("exc_idx", exc_idx, e_exci);
        check("exc_op", exc_op, e_exco);
      end
      for (int i = 0; i < W; i++) begin
        check("disp_idx", disp_idx[i*IW +: IW], (m_tail + i) % D);
        if (e_cmv[i]) begin
          check("cm_arch", cm_arch[i*AW +: AW], e_arch[i]);
          check("cm_phys", cm_phys[i*PW +: PW], e_phys[i]);
        end
      end
    end
  end
  always @(posedge clk)
    if (reset) assert ((disp_valid & (disp_valid + 1'b1)) == '0) else $error("protocol: disp_valid not contiguous");
  task automatic cyc();
    @(posedge clk);
    if (reset) model_step();
    @(negedge clk);
  endtask
  task automatic idle();
    disp_valid = '0;
    wb_valid = '0;
    wb_exc = '0;
  endtask
  task automatic disp(input int n);
    disp_valid = W'((1 << n) - 1);
    disp_arch = W*AW'({$urandom, $urandom});
    disp_phys = W*PW'({$urandom, $urandom});
    disp_op = W*OW'({$urandom, $urandom});
  endtask
  task automatic set_wb(input int p, input int idx, input bit e);
    wb_valid[p] = 1'b1;
    wb_idx[p*IW +: IW] = IW'(idx);
    wb_exc[p] = e;
  endtask
  task automatic do_reset();
    #2 reset = 0;
    model_reset();
    cyc();
    #2 reset = 1;
  endtask
  task automatic drain();
    int n;
    for (int c = 0; c < 400 && (mq.size() != 0 || m_flush); c++) begin
      idle();
      n = 0;
      for (int j = 0; j < mq.size() && n < P; j++)
        if (!mq[j].done) begin
          set_wb(n, mq[j].idx, 0);
          n++;
        end
      cyc();
    end
    idle();
    check("drain_empty", empty, 1);
  endtask
  initial begin
    model_reset();
    #1 reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    chk_en = 1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", disp_ready, 1);
    check("rst_cm_valid", cm_valid, 0);
    check("rst_num_commit", num_commit, 0);
    check("rst_exc_valid", exc_valid, 0);
    check("rst_exc_idx", exc_idx, 0);
    // fill to capacity, then a dropped dispatch
    for (int c = 0; c < 32; c++) begin
      disp(4);
      cyc();
    end
    idle();
    check("fill_full", full, 1);
    check("fill_count", count, 128);
    check("fill_ready", disp_ready, 0);
    disp(4);
    cyc();
    idle();
    check("drop_count", count, 128);
    drain();
    // out-of-order writeback, in-order retire
    do_reset();
    disp(4);
    cyc();
    idle();
    set_wb(0, 3, 0);
    set_wb(1, 2, 0);
    set_wb(2, 1, 0);
    cyc();
    idle();
    check("ooo_cm_none", cm_valid, 0);
    set_wb(0, 0, 0);
    cyc();
    idle();
    check("ooo_cm_wait", cm_valid, 0);
    cyc();
    check("ooo_cm_all", cm_valid, 4'b1111);
    check("ooo_num", num_commit, 4);
    check("ooo_head", disp_idx[IW-1:0], 4);
    // exception behind an ok entry
    do_reset();
    disp(4);
    cyc();
    idle();
    set_wb(0, 0, 0);
    set_wb(1, 1, 1);
    cyc();
    idle();
    cyc();
    check("exc_cm", cm_valid, 4'b0001);
    check("exc_v", exc_valid, 1);
    check("exc_i", exc_idx, 1);
    check("exc_cnt", count, 3);
    check("exc_rdy_flush", disp_ready, 0);
    cyc();
    check("flush_count", count, 0);
    check("flush_empty", empty, 1);
    check("flush_ready", disp_ready, 1);
    check("flush_excv", exc_valid, 0);
    // wrap-around of tail and head
    do_reset();
    for (int c = 0; c < 31; c++) begin
      disp(4);
      cyc();
    end
    idle();
    drain();
    disp(2);
    cyc();
    idle();
    drain();
    disp(4);
    check("wrap_idx0", disp_idx[0*IW +: IW], 126);
    check("wrap_idx1", disp_idx[1*IW +: IW], 127);
    check("wrap_idx2", disp_idx[2*IW +: IW], 0);
    check("wrap_idx3", disp_idx[3*IW +: IW], 1);
    cyc();
    idle();
    set_wb(0, 0, 0);
    set_wb(1, 127, 0);
    set_wb(2, 1, 0);
    set_wb(3, 126, 0);
    cyc();
    idle();
    cyc();
    check("wrap_cm", cm_valid, 4'b1111);
    check("wrap_count", count, 0);
    check("wrap_head", disp_idx[IW-1:0], 2);
    // dispatch and commit in the same cycle
    do_reset();
    disp(4);
    cyc();
    disp(4);
    cyc();
    disp(2);
    cyc();
    idle();
    check("same_cnt10", count, 10);
    set_wb(0, 0, 0);
    set_wb(1, 1, 0);
    cyc();
    idle();
    disp(3);
    cyc();
    idle();
    check("same_cnt11", count, 11);
    check("same_nc", num_commit, 2);
    drain();
    // asynchronous reset during flush
    do_reset();
    disp(4);
    cyc();
    idle();
    set_wb(0, 0, 1);
    cyc();
    idle();
    cyc();
    check("rf_excv", exc_valid, 1);
    #2 reset = 0;
    model_reset();
    #1;
    check("rf_excv_rst", exc_valid, 0);
    check("rf_count_rst", count, 0);
    check("rf_ready_rst", disp_ready, 1);
    @(negedge clk);
    #2 reset = 1;
    disp(4);
    cyc();
    idle();
    check("rf_after", count, 4);
    drain();
    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 2) != 0) disp($urandom_range(0, W));
      for (int p = 0; p < P; p++) begin
        if (mq.size() > 0 && $urandom_range(0, 1) == 1)
          set_wb(p, mq[$urandom_range(0, mq.size() - 1)].idx, $urandom_range(0, 40) == 0);
        else if ($urandom_range(0, 7) == 0)
          set_wb(p, $urandom_range(0, D - 1), $urandom_range(0, 1));
      end
      cyc();
    end
    idle();
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
